// File: rtl/timer_pkg.sv
// timer_pkg: register map, CTRL bit positions and shared types for machine_timer
package timer_pkg;
  localparam logic [2:0] MTIME_LO  = 3'd0;
  localparam logic [2:0] MTIME_HI  = 3'd1;
  localparam logic [2:0] CMP_LO    = 3'd2;
  localparam logic [2:0] CMP_HI    = 3'd3;
  localparam logic [2:0] CTRL      = 3'd4;
  localparam logic [2:0] PRESCALE  = 3'd5;
  localparam logic [2:0] PERIOD_LO = 3'd6;
  localparam logic [2:0] PERIOD_HI = 3'd7;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IE     = 1;
  localparam int CTRL_RELOAD = 2;
  localparam int CTRL_PEND   = 3;
  localparam logic [63:0] CMP_RESET = '1;
  typedef struct packed {
    logic reload;
    logic ie;
    logic enable;
  } ctrl_t;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the core clock into mtime ticks (tick every prescale+1 enabled cycles)
module timer_prescaler #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);
  logic [PRESCALE_WIDTH-1:0] r_count;
  assign tick = enable && (r_count == prescale);
  // tick counter: wraps on tick, holds while disabled, restarts when prescale is rewritten
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) r_count <= '0;
    else if (clear) r_count <= '0;
    else if (enable) r_count <= tick ? '0 : r_count + PRESCALE_WIDTH'(1);
endmodule

// File: rtl/machine_timer.sv
// machine_timer: 64-bit mtime/mtimecmp timer with one-shot interrupt handshake; TIMER_AUTORELOAD_EN adds periodic reload
module machine_timer #(
  parameter int PRESCALE_WIDTH = 16,
  parameter bit RESET_ENABLE   = 1'b0
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        chipSelect,
  input  logic        memoryWriteEnable,
  input  logic [2:0]  address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  input  logic        isReturn,
  output logic        timerInterrupt,
  output logic        interruptPending
);
  import timer_pkg::*;
  logic [63:0] r_mtime, r_cmp, w_period;
  logic [31:0] r_shadow_hi;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  ctrl_t r_ctrl;
  logic r_pending, r_in_service, r_match_q;
  logic w_wr, w_tick, w_match, w_clr, w_set, w_reload_en;
  assign w_wr = chipSelect && memoryWriteEnable;
  assign w_match = r_ctrl.enable && (r_mtime >= r_cmp);
  assign w_clr = w_wr && (address == CMP_LO || address == CMP_HI || (address == CTRL && writeData[CTRL_PEND]));
  assign w_set = w_match && !r_match_q && !w_clr;
  assign timerInterrupt = r_pending && r_ctrl.ie && !r_in_service;
  assign interruptPending = r_pending;
  timer_prescaler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_prescaler (
    .clk(clk),
    .resetN(resetN),
    .enable(r_ctrl.enable),
    .clear(w_wr && address == PRESCALE),
    .prescale(r_prescale),
    .tick(w_tick)
  );
`ifdef TIMER_AUTORELOAD_EN
  logic [63:0] r_period;
  assign w_period = r_period;
  assign w_reload_en = 1'b1;
  // reload period, written per 32-bit half
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) r_period <= '0;
    else if (w_wr && address == PERIOD_LO) r_period <= {r_period[63:32], writeData};
    else if (w_wr && address == PERIOD_HI) r_period <= {writeData, r_period[31:0]};
`else
  assign w_period = '0;
  assign w_reload_en = 1'b0;
`endif
  // timer state: bus writes beat ticks/reloads; a pending clear beats a match edge
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      r_mtime <= '0;
      r_cmp <= CMP_RESET;
      r_ctrl <= '{reload: 1'b0, ie: 1'b0, enable: RESET_ENABLE};
      r_prescale <= '0;
      r_shadow_hi <= '0;
      r_pending <= 1'b0;
      r_in_service <= 1'b0;
      r_match_q <= 1'b0;
    end else begin
      r_mtime <= (w_wr && address == MTIME_LO) ? {r_mtime[63:32], writeData} :
                 (w_wr && address == MTIME_HI) ? {writeData, r_mtime[31:0]} :
                 r_mtime + 64'(w_tick);
      r_cmp <= (w_wr && address == CMP_LO) ? {r_cmp[63:32], writeData} :
               (w_wr && address == CMP_HI) ? {writeData, r_cmp[31:0]} :
               (r_ctrl.reload && w_set) ? r_cmp + w_period : r_cmp;
      if (w_wr && address == CTRL)
        r_ctrl <= '{reload: writeData[CTRL_RELOAD] && w_reload_en, ie: writeData[CTRL_IE], enable: writeData[CTRL_EN]};
      if (w_wr && address == PRESCALE) r_prescale <= writeData[PRESCALE_WIDTH-1:0];
      if (chipSelect && !memoryWriteEnable && address == MTIME_LO) r_shadow_hi <= r_mtime[63:32];
      r_match_q <= w_match;
      r_pending <= !w_clr && (w_set || r_pending);
      r_in_service <= !isReturn && (timerInterrupt || r_in_service);
    end
  // read mux; MTIME_HI returns the high word captured by the last MTIME_LO read
  always_comb begin
    readData = '0;
    if (chipSelect)
      case (address)
        MTIME_LO:  readData = r_mtime[31:0];
        MTIME_HI:  readData = r_shadow_hi;
        CMP_LO:    readData = r_cmp[31:0];
        CMP_HI:    readData = r_cmp[63:32];
        CTRL:      readData = {28'b0, r_pending, r_ctrl};
        PRESCALE:  readData = 32'(r_prescale);
        PERIOD_LO: readData = w_period[31:0];
        PERIOD_HI: readData = w_period[63:32];
        default:   readData = '0;
      endcase
  end
endmodule

// File: tb/tb_machine_timer.sv
// tb_machine_timer: directed scenarios for machine_timer with inline expected values
module tb_machine_timer;
  logic clk = 1'b0, resetN = 1'b1, chipSelect = 1'b0, memoryWriteEnable = 1'b0, isReturn = 1'b0;
  logic [2:0] address = 3'd0;
  logic [31:0] writeData = '0, readData, rd;
  logic timerInterrupt, interruptPending;
  int n_cmp = 0, n_bad = 0;

  machine_timer dut (
    .clk(clk), .resetN(resetN), .chipSelect(chipSelect), .memoryWriteEnable(memoryWriteEnable),
    .address(address), .writeData(writeData), .readData(readData), .isReturn(isReturn),
    .timerInterrupt(timerInterrupt), .interruptPending(interruptPending)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipSelect = 1'b1; memoryWriteEnable = 1'b1; address = a; writeData = d;
    @(negedge clk);
    chipSelect = 1'b0; memoryWriteEnable = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    chipSelect = 1'b1; memoryWriteEnable = 1'b0; address = a;
    #1 d = readData;
    @(negedge clk);
    chipSelect = 1'b0;
  endtask

  task automatic do_reset;
    resetN = 1'b0; chipSelect = 1'b0; memoryWriteEnable = 1'b0; isReturn = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_reset;
    #2 resetN = 1'b0;
    #1;
    n_cmp++; if (timerInterrupt !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %b want 0", timerInterrupt); end
    n_cmp++; if (interruptPending !== 1'b0) begin n_bad++; $display("FAIL rst_pend: got %b want 0", interruptPending); end
    n_cmp++; if (readData !== 32'h0) begin n_bad++; $display("FAIL rst_rd_idle: got %h want 0", readData); end
    chipSelect = 1'b1; address = 3'd2; #1;
    n_cmp++; if (readData !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_cmp_lo: got %h want ffffffff", readData); end
    address = 3'd3; #1;
    n_cmp++; if (readData !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_cmp_hi: got %h want ffffffff", readData); end
    address = 3'd4; #1;
    n_cmp++; if (readData !== 32'h0) begin n_bad++; $display("FAIL rst_ctrl: got %h want 0", readData); end
    address = 3'd0; #1;
    n_cmp++; if (readData !== 32'h0) begin n_bad++; $display("FAIL rst_mtime: got %h want 0", readData); end
    chipSelect = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_prescale;
    do_reset;
    bus_write(3'd5, 32'd3);
    bus_write(3'd4, 32'h1);
    repeat (40) @(negedge clk);
    bus_read(3'd0, rd);
    n_cmp++; if (rd !== 32'd10) begin n_bad++; $display("FAIL presc_mtime_lo: got %0d want 10", rd); end
    bus_read(3'd1, rd);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL presc_mtime_hi: got %0d want 0", rd); end
    bus_read(3'd5, rd);
    n_cmp++; if (rd !== 32'd3) begin n_bad++; $display("FAIL presc_reg: got %0d want 3", rd); end
    #1;
    n_cmp++; if (readData !== 32'h0) begin n_bad++; $display("FAIL rd_idle: got %h want 0", readData); end
  endtask

  task automatic test_fire;
    do_reset;
    bus_write(3'd3, 32'd0);
    bus_write(3'd2, 32'd5);
    bus_write(3'd4, 32'h3);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_cmp++; if (timerInterrupt !== 1'(k == 6)) begin n_bad++; $display("FAIL fire_irq k=%0d: got %b want %b", k, timerInterrupt, k == 6); end
      n_cmp++; if (interruptPending !== 1'(k >= 6)) begin n_bad++; $display("FAIL fire_pend k=%0d: got %b want %b", k, interruptPending, k >= 6); end
    end
  endtask

  task automatic test_refire;
    isReturn = 1'b1; #1;
    n_cmp++; if (timerInterrupt !== 1'b0) begin n_bad++; $display("FAIL refire_in_ret: got %b want 0", timerInterrupt); end
    @(negedge clk);
    isReturn = 1'b0; #1;
    n_cmp++; if (timerInterrupt !== 1'b1) begin n_bad++; $display("FAIL refire_after_ret: got %b want 1", timerInterrupt); end
    @(negedge clk);
    n_cmp++; if (timerInterrupt !== 1'b0) begin n_bad++; $display("FAIL refire_one_cycle: got %b want 0", timerInterrupt); end
    bus_write(3'd2, 32'd100);
    n_cmp++; if (interruptPending !== 1'b0) begin n_bad++; $display("FAIL cmp_write_clr: got %b want 0", interruptPending); end
    isReturn = 1'b1;
    @(negedge clk);
    isReturn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (timerInterrupt !== 1'b0) begin n_bad++; $display("FAIL no_refire k=%0d: got %b want 0", k, timerInterrupt); end
    end
  endtask

  task automatic test_coherent_read;
    do_reset;
    bus_write(3'd4, 32'h1);
    bus_write(3'd1, 32'h0);
    bus_write(3'd0, 32'hFFFF_FFFF);
    bus_read(3'd0, rd);
    n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL coh_lo: got %h want ffffffff", rd); end
    bus_read(3'd1, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL coh_hi_shadow: got %h want 0", rd); end
    bus_read(3'd0, rd);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL coh_lo2: got %h want 1", rd); end
    bus_read(3'd1, rd);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL coh_hi_live: got %h want 1", rd); end
  endtask

  task automatic test_async_reset;
    do_reset;
    bus_write(3'd3, 32'd0);
    bus_write(3'd2, 32'd3);
    bus_write(3'd4, 32'h3);
    for (int i = 0; i < 20 && timerInterrupt !== 1'b1; i++) @(negedge clk);
    n_cmp++; if (timerInterrupt !== 1'b1) begin n_bad++; $display("FAIL arst_wait_irq: got %b want 1", timerInterrupt); end
    resetN = 1'b0; #1;
    n_cmp++; if (timerInterrupt !== 1'b0) begin n_bad++; $display("FAIL arst_irq: got %b want 0", timerInterrupt); end
    n_cmp++; if (interruptPending !== 1'b0) begin n_bad++; $display("FAIL arst_pend: got %b want 0", interruptPending); end
    chipSelect = 1'b1; address = 3'd0; #1;
    n_cmp++; if (readData !== 32'h0) begin n_bad++; $display("FAIL arst_mtime: got %h want 0", readData); end
    chipSelect = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_clear_precedence;
    do_reset;
    bus_write(3'd3, 32'd0);
    bus_write(3'd2, 32'd5);
    bus_write(3'd4, 32'h3);
    repeat (5) @(negedge clk);
    bus_write(3'd2, 32'd5);
    n_cmp++; if (interruptPending !== 1'b0) begin n_bad++; $display("FAIL clr_beats_set: got %b want 0", interruptPending); end
    repeat (3) @(negedge clk);
    n_cmp++; if (interruptPending !== 1'b0) begin n_bad++; $display("FAIL no_late_set: got %b want 0", interruptPending); end
    bus_write(3'd2, 32'd40);
    for (int i = 0; i < 80 && interruptPending !== 1'b1; i++) @(negedge clk);
    n_cmp++; if (interruptPending !== 1'b1) begin n_bad++; $display("FAIL pend_wait: got %b want 1", interruptPending); end
    bus_read(3'd4, rd);
    n_cmp++; if (rd !== 32'hB) begin n_bad++; $display("FAIL ctrl_pend_rd: got %h want b", rd); end
    bus_write(3'd4, 32'h3);
    n_cmp++; if (interruptPending !== 1'b1) begin n_bad++; $display("FAIL ctrl_w0_keeps: got %b want 1", interruptPending); end
    bus_write(3'd4, 32'hB);
    n_cmp++; if (interruptPending !== 1'b0) begin n_bad++; $display("FAIL ctrl_w1_clr: got %b want 0", interruptPending); end
    bus_read(3'd4, rd);
    n_cmp++; if (rd !== 32'h3) begin n_bad++; $display("FAIL ctrl_after_clr: got %h want 3", rd); end
    bus_write(3'd4, 32'h7);
    bus_read(3'd4, rd);
`ifdef TIMER_AUTORELOAD_EN
    n_cmp++; if (rd !== 32'h7) begin n_bad++; $display("FAIL ctrl_reload_rd: got %h want 7", rd); end
`else
    n_cmp++; if (rd !== 32'h3) begin n_bad++; $display("FAIL ctrl_reload_rd: got %h want 3", rd); end
`endif
    bus_write(3'd6, 32'd10);
    bus_read(3'd6, rd);
`ifdef TIMER_AUTORELOAD_EN
    n_cmp++; if (rd !== 32'd10) begin n_bad++; $display("FAIL period_rd: got %h want a", rd); end
`else
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL period_rd: got %h want 0", rd); end
`endif
  endtask

`ifdef TIMER_AUTORELOAD_EN
  task automatic test_autoreload;
    do_reset;
    bus_write(3'd6, 32'd10);
    bus_write(3'd7, 32'd0);
    bus_write(3'd3, 32'd0);
    bus_write(3'd2, 32'd10);
    bus_write(3'd4, 32'h7);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      n_cmp++; if (timerInterrupt !== 1'(k == 11 || k == 21 || k == 31)) begin n_bad++; $display("FAIL reload_irq k=%0d: got %b", k, timerInterrupt); end
      if (timerInterrupt) begin
        isReturn = 1'b1; chipSelect = 1'b1; memoryWriteEnable = 1'b1; address = 3'd4; writeData = 32'hF;
      end else begin
        isReturn = 1'b0; chipSelect = 1'b0; memoryWriteEnable = 1'b0;
      end
    end
    isReturn = 1'b0; chipSelect = 1'b0; memoryWriteEnable = 1'b0;
    bus_read(3'd2, rd);
    n_cmp++; if (rd !== 32'd40) begin n_bad++; $display("FAIL reload_cmp: got %0d want 40", rd); end
  endtask
`endif

  initial begin
    test_reset;
    test_prescale;
    test_fire;
    test_refire;
    test_coherent_read;
    test_async_reset;
    test_clear_precedence;
`ifdef TIMER_AUTORELOAD_EN
    test_autoreload;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
